// File: rtl/period_meas_scheduler.sv
// period_meas_scheduler
// Round-robin front end that shares one period counter between N_CH channels.
// A winning channel is steered onto the counter input, given one settle cycle,
// launched with a one-cycle start pulse, and receives its 10-bit period result
// together with a one-cycle ack after the counter reports completion.
//
// Optional build macro PSCHED_SCAN_EN: adds scan_en/scan_tick so that an idle
// scheduler sweeps the channels by itself; real requests always take priority.
//
// Handshake (req/ack): req is a level held by the requester until it sees its
// ack bit; req is sampled only while IDLE; ack is a single-cycle pulse on the
// served bit and result/res_ch are valid in that cycle and held afterwards.
// Counter side: pc_start is issued only when pc_ready was seen high in IDLE,
// and pc_prd is taken only in the cycle pc_done_tick is high.
module period_meas_scheduler #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] req,
    input  logic [N_CH-1:0] si_ch,
    output logic [N_CH-1:0] ack,
    output logic [9:0]      result,
    output logic [CH_W-1:0] res_ch,
    output logic            busy,
    output logic            pc_si,
    output logic            pc_start,
    input  logic            pc_ready,
    input  logic            pc_done_tick,
    input  logic [9:0]      pc_prd,
`ifdef PSCHED_SCAN_EN
    input  logic            scan_en,
    output logic            scan_tick,
`endif
    output logic [2:0]      dbg_state,
    output logic [CH_W-1:0] dbg_rr_ptr
);

    // Elaboration-time guard on the channel configuration.
    if (N_CH < 2 || N_CH > 8 || (1 << CH_W) < N_CH) begin : g_bad_cfg
        $error("period_meas_scheduler: unsupported N_CH/CH_W combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_MEAS   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] sel_q, sel_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [9:0]      result_q, result_d;
    logic [CH_W-1:0] res_ch_q, res_ch_d;
    logic            scan_q, scan_d;

    logic [CH_W-1:0] rr_pick;
    logic            rr_found;
    logic [CH_W-1:0] rr_next;
    logic            scan_req;

    // Channel index base+off reduced modulo N_CH (off is always < N_CH).
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_CH) s = s - N_CH;
        return CH_W'(s);
    endfunction

`ifdef PSCHED_SCAN_EN
    assign scan_req = scan_en;
`else
    assign scan_req = 1'b0;
`endif

    // Round-robin search: first requester at or after rr_ptr, wrapping upward.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = rr_ptr_q;
        for (int i = 0; i < N_CH; i++) begin
            if (!rr_found && req[wrap_add(rr_ptr_q, i)]) begin
                rr_found = 1'b1;
                rr_pick  = wrap_add(rr_ptr_q, i);
            end
        end
    end

    // Pointer after serving sel: one past it, wrapping at the last channel.
    always_comb begin
        rr_next = (sel_q == CH_W'(N_CH - 1)) ? '0 : sel_q + CH_W'(1);
    end

    // Next-state and output decode; every output defaults to its idle value.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        result_d  = result_q;
        res_ch_d  = res_ch_q;
        scan_d    = scan_q;
        pc_start  = 1'b0;
        ack       = '0;
`ifdef PSCHED_SCAN_EN
        scan_tick = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A busy counter blocks both real requests and scans.
                if (pc_ready) begin
                    if (rr_found) begin
                        sel_d   = rr_pick;
                        scan_d  = 1'b0;
                        state_d = ST_SETTLE;
                    end else if (scan_req) begin
                        sel_d   = rr_ptr_q;
                        scan_d  = 1'b1;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                // New channel is already on pc_si; let the counter's edge
                // detector see it for a cycle before it is armed.
                state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                pc_start = 1'b1;
                state_d  = ST_MEAS;
            end
            ST_MEAS: begin
                // No timeout: a silent channel keeps the scheduler here.
                if (pc_done_tick) begin
                    result_d = pc_prd;
                    res_ch_d = sel_q;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (scan_q) begin
`ifdef PSCHED_SCAN_EN
                    scan_tick = 1'b1;
`endif
                end else begin
                    ack[sel_q] = 1'b1;
                end
                rr_ptr_d = rr_next;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any measurement in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            result_q <= '0;
            res_ch_q <= '0;
            scan_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            result_q <= result_d;
            res_ch_q <= res_ch_d;
            scan_q   <= scan_d;
        end
    end

    // Steering mux and status outputs, all from registered state.
    always_comb begin
        pc_si      = si_ch[sel_q];
        busy       = (state_q != ST_IDLE);
        result     = result_q;
        res_ch     = res_ch_q;
        dbg_state  = state_q;
        dbg_rr_ptr = rr_ptr_q;
    end

endmodule

// File: tb/tb_period_meas_scheduler.sv
// Bench for period_meas_scheduler: behavioural period counter, round-robin
// reference model and a queue of expected period values.
module tb_period_meas_scheduler;
    localparam int N_CH = 4;
    localparam int CH_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] si_ch;
    logic [N_CH-1:0] ack;
    logic [9:0]      result;
    logic [CH_W-1:0] res_ch;
    logic            busy;
    logic            pc_si;
    logic            pc_start;
    logic            pc_ready;
    logic            pc_done_tick;
    logic [9:0]      pc_prd;
    logic [2:0]      dbg_state;
    logic [CH_W-1:0] dbg_rr_ptr;
    logic            scan_tick_w;
`ifdef PSCHED_SCAN_EN
    logic            scan_en;
    logic            scan_tick;
    assign scan_tick_w = scan_tick;
`else
    assign scan_tick_w = 1'b0;
`endif

    period_meas_scheduler #(.N_CH(N_CH), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .req(req), .si_ch(si_ch), .ack(ack),
        .result(result), .res_ch(res_ch), .busy(busy), .pc_si(pc_si),
        .pc_start(pc_start), .pc_ready(pc_ready), .pc_done_tick(pc_done_tick),
        .pc_prd(pc_prd),
`ifdef PSCHED_SCAN_EN
        .scan_en(scan_en), .scan_tick(scan_tick),
`endif
        .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural period counter
    logic       cm_ready;
    logic       block_ready;
    int         cm_cnt;
    int         cm_len;
    bit         cm_use_fixed;
    logic [9:0] cm_prd_fixed;
    logic [9:0] cm_cur;
    logic [9:0] cm_next;
    logic [9:0] exp_q[$];

    assign pc_ready = cm_ready & ~block_ready;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cm_ready     <= 1'b1;
            pc_done_tick <= 1'b0;
            pc_prd       <= '0;
            cm_cnt       <= 0;
        end else begin
            pc_done_tick <= 1'b0;
            pc_prd       <= 10'($urandom);
            if (pc_start) begin
                cm_next = cm_use_fixed ? cm_prd_fixed : 10'($urandom_range(1, 1023));
                exp_q.push_back(cm_next);
                cm_cur   <= cm_next;
                cm_cnt   <= cm_len;
                cm_ready <= 1'b0;
            end else if (cm_cnt > 1) begin
                cm_cnt <= cm_cnt - 1;
            end else if (cm_cnt == 1) begin
                cm_cnt       <= 0;
                pc_done_tick <= 1'b1;
                pc_prd       <= cm_cur;
            end else if (!cm_ready) begin
                cm_ready <= 1'b1;
            end
        end
    end

    // Scoreboard counters and comparison
    int n_vec = 0;
    int n_err = 0;
    int m_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first requester at or after ptr, cyclically.
    function automatic int ref_pick(input logic [N_CH-1:0] r, input int ptr);
        for (int k = 0; k < N_CH; k++) begin
            if (r[(ptr + k) % N_CH]) return (ptr + k) % N_CH;
        end
        return ptr;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_ptr = 0;
        @(negedge clk);
    endtask

    // Bounded wait for pc_start; returns cycles counted from the call.
    task automatic wait_start(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!pc_start && cycles < 200);
        chk("start_seen", {31'd0, pc_start}, 32'd1);
    endtask

    // Follow one grant from launch to ack (or scan tick) and check it.
    task automatic observe_grant(input int exp_ch, input int exp_lat, input bit exp_scan,
                                 input bit set_in_meas, input logic [N_CH-1:0] req_in_meas);
        int         cyc;
        int         guard;
        logic       prev_done;
        logic [9:0] expv;
        wait_start(cyc);
        if (exp_lat >= 0) chk("start_latency", cyc, exp_lat);
        si_ch = 4'($urandom);
        #1;
        chk("pc_si_steer", {31'd0, pc_si}, {31'd0, si_ch[exp_ch]});
        @(negedge clk);
        chk("start_one_cycle", {31'd0, pc_start}, 32'd0);
        if (set_in_meas) req = req_in_meas;
        guard     = 0;
        prev_done = 1'b0;
        while (ack == '0 && !scan_tick_w && guard < 300) begin
            prev_done = pc_done_tick;
            @(negedge clk);
            guard++;
        end
        chk("done_before_ack", {31'd0, prev_done}, 32'd1);
        chk("ack_bits", {28'd0, ack}, exp_scan ? 32'd0 : (32'd1 << exp_ch));
`ifdef PSCHED_SCAN_EN
        chk("scan_tick", {31'd0, scan_tick}, {31'd0, exp_scan});
`endif
        chk("res_ch", {30'd0, res_ch}, exp_ch);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        chk("result", {22'd0, result}, {22'd0, expv});
        @(negedge clk);
        chk("ack_single", {28'd0, ack}, 32'd0);
        chk("rr_ptr", {30'd0, dbg_rr_ptr}, (exp_ch + 1) % N_CH);
        m_ptr = (exp_ch + 1) % N_CH;
    endtask

    // Directed and randomized steps
    initial begin
        int g;
        int cyc;
        req          = '0;
        si_ch        = '0;
        block_ready  = 1'b0;
        cm_use_fixed = 1'b0;
        cm_prd_fixed = '0;
        cm_len       = 3;
        reset        = 1'b1;
`ifdef PSCHED_SCAN_EN
        scan_en      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_result", {22'd0, result}, 32'd0);
        chk("rst_res_ch", {30'd0, res_ch}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pc_start", {31'd0, pc_start}, 32'd0);
        chk("rst_rr_ptr", {30'd0, dbg_rr_ptr}, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single request on channel 2 with a fixed 250 ms period.
        cm_use_fixed = 1'b1;
        cm_prd_fixed = 10'd250;
        cm_len       = 5;
        req          = 4'b0100;
        observe_grant(ref_pick(req, m_ptr), 2, 1'b0, 1'b0, '0);
        chk("t1_result", {22'd0, result}, 32'd250);
        chk("t1_res_ch", {30'd0, res_ch}, 32'd2);
        req = '0;

        // All channels requesting continuously: five grants in rotation.
        do_reset();
        cm_use_fixed = 1'b0;
        req          = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cm_len = $urandom_range(1, 6);
            g = ref_pick(req, m_ptr);
            chk("t2_order", g, i % N_CH);
            observe_grant(g, 2, 1'b0, 1'b0, '0);
        end
        req = '0;
        @(negedge clk);
        chk("t2_idle_busy", {31'd0, busy}, 32'd0);

        // Counter not ready: requests wait, then launch two cycles after ready.
        block_ready = 1'b1;
        req         = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_no_start", {31'd0, pc_start}, 32'd0);
            chk("t3_not_busy", {31'd0, busy}, 32'd0);
        end
        block_ready = 1'b0;
        cm_len      = 4;
        observe_grant(ref_pick(req, m_ptr), 2, 1'b0, 1'b0, '0);
        req = '0;

        // Reset in the middle of a long measurement.
        cm_len = 40;
        req    = 4'b1000;
        wait_start(cyc);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        req   = '0;
        #1;
        chk("t4_ack", {28'd0, ack}, 32'd0);
        chk("t4_result", {22'd0, result}, 32'd0);
        chk("t4_res_ch", {30'd0, res_ch}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_pc_start", {31'd0, pc_start}, 32'd0);
        chk("t4_rr_ptr", {30'd0, dbg_rr_ptr}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_ack", {28'd0, ack}, 32'd0);
        end
        reset = 1'b0;
        exp_q.delete();
        m_ptr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_post_ack", {28'd0, ack}, 32'd0);
        end
        cm_len = 4;
        req    = 4'b0010;
        observe_grant(ref_pick(req, m_ptr), 2, 1'b0, 1'b0, '0);
        chk("t4_served_ch", {30'd0, res_ch}, 32'd1);
        req = '0;

        // Requester withdraws during measurement: ack still pulses.
        cm_use_fixed = 1'b1;
        cm_prd_fixed = 10'd1023;
        cm_len       = 6;
        req          = 4'b1000;
        observe_grant(ref_pick(req, m_ptr), 2, 1'b0, 1'b1, 4'b0000);
        chk("t5_result", {22'd0, result}, 32'd1023);

        // Randomized request patterns against the round-robin model.
        cm_use_fixed = 1'b0;
        req          = 4'($urandom_range(1, 15));
        for (int i = 0; i < 14; i++) begin
            cm_len = $urandom_range(1, 8);
            g = ref_pick(req, m_ptr);
            observe_grant(g, 2, 1'b0, 1'b0, '0);
            req[g] = 1'b0;
            req    = req | (4'($urandom) & 4'($urandom));
            if (req == '0) req = 4'($urandom_range(1, 15));
        end
        req = '0;

`ifdef PSCHED_SCAN_EN
        // Idle scanning, with a real request arriving mid-scan.
        do_reset();
        scan_en = 1'b1;
        cm_len  = 3;
        observe_grant(0, 2, 1'b1, 1'b0, '0);
        observe_grant(1, 2, 1'b1, 1'b1, 4'b1000);
        observe_grant(ref_pick(req, m_ptr), 2, 1'b0, 1'b0, '0);
        req = '0;
        observe_grant(m_ptr, 2, 1'b1, 1'b0, '0);
        scan_en = 1'b0;
        repeat (10) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/period_meas_scheduler.md
Name: period_meas_scheduler

Overview:
- Shares one period-counter datapath between N_CH requesting channels.
- Round-robin arbitrates requests and steers the winning channel's signal onto the counter's measurement input.
- Sequences the counter's start/ready/done_tick handshake and returns the 10-bit period (ms units) to the winner with a one-cycle ack.
- Sits between per-channel measurement clients and a single period counter instance in the top level.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- CH_W, 2, channel index width; must satisfy 2**CH_W >= N_CH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_CH  per-channel measurement request, level; requester holds it until its ack.
- si_ch  in  N_CH  per-channel input signals to be measured.
- ack  out  N_CH  one-cycle pulse to the served channel; result is valid in that cycle.
- result  out  10  last captured period; held until the next capture.
- res_ch  out  CH_W  channel index of the last captured result; held.
- busy  out  1  high whenever the FSM is not in IDLE.
- pc_si  out  1  steered signal to the counter's si input; equals si_ch[sel_reg].
- pc_start  out  1  one-cycle start pulse to the counter.
- pc_ready  in  1  counter idle/ready flag.
- pc_done_tick  in  1  counter completion tick.
- pc_prd  in  10  counter period value; valid during pc_done_tick.

Behaviour:
- Reset values: ack=0, result=0, res_ch=0, busy=0, pc_start=0, sel_reg=0, rr_ptr=0, state=IDLE.
- Reset asserted mid-measurement aborts immediately to IDLE; no ack is issued. The counter must share the same reset.
- States: IDLE, SETTLE, LAUNCH, MEAS, RESP. Unknown encodings go to IDLE.
- IDLE:
  - If |req and pc_ready, pick the first requesting channel at or after rr_ptr (cyclic search upward, wrapping N_CH-1 to 0).
  - Load sel_reg, go to SETTLE.
  - If pc_ready=0, stay in IDLE regardless of req.
- SETTLE:
  - One cycle with the new sel_reg driving pc_si, so the counter's edge detector samples the new channel before start.
  - No spurious edge may be produced by the mux switch. Go to LAUNCH.
- LAUNCH: pc_start=1 for exactly this cycle, then go to MEAS.
- MEAS:
  - Wait for pc_done_tick. On that cycle, register result<=pc_prd and res_ch<=sel_reg, then go to RESP.
  - No timeout: a channel with no edges holds the scheduler in MEAS indefinitely.
- RESP:
  - ack[sel_reg]=1 for one cycle; all other ack bits stay 0.
  - rr_ptr<=sel_reg+1, wrapping to 0 when sel_reg=N_CH-1. Go to IDLE.
- Latency:
  - From req seen in IDLE (counter ready) to pc_start is 2 cycles.
  - ack is asserted the cycle after pc_done_tick.
  - Minimum spacing between consecutive grants is 5 cycles plus the measurement time.
- If req drops during MEAS, the measurement still completes and the ack pulse is still issued; the requester ignores it.
- req changes in states other than IDLE are not sampled.
- Simultaneous requests are served one per pass in round-robin order, so no channel starves.
- sel_reg changes only on the IDLE->SETTLE transition.

Optional Feature:
- Macro PSCHED_SCAN_EN.
- Defined:
  - Adds input scan_en (1) and output scan_tick (1).
  - In IDLE with req=0, scan_en=1 and pc_ready=1, the scheduler selects rr_ptr itself and runs the normal SETTLE..MEAS sequence.
  - In RESP it pulses scan_tick instead of ack; result, res_ch and rr_ptr update normally.
  - Real requests always win over scan in IDLE. Scan never preempts a running measurement.
- Undefined: scan_en and scan_tick ports do not exist; behaviour is exactly as above.

Test Plan:
- Bench uses a behavioural counter model: ready high in idle; done_tick N cycles after start, with a programmable pc_prd.
- Reset, then req=4'b0100, model returns pc_prd=10'd250 -> pc_start pulses 2 cycles after req; ack=4'b0100 one cycle after done_tick; result=250; res_ch=2; rr_ptr=3.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0; each ack single-cycle; results match per-grant model values.
- pc_ready=0 with req=4'b0001 for 20 cycles -> no pc_start, busy=0; pc_ready rises -> start follows 2 cycles later.
- Assert reset during MEAS -> all outputs return to reset values; no ack; next req=4'b0010 is served normally with channel 1 chosen.
- req[3] drops during MEAS with pc_prd=10'd1023 -> ack[3] still pulses; result=1023.
- PSCHED_SCAN_EN, scan_en=1, req=0 -> channels 0,1,2,3 measured cyclically with scan_tick pulses; req=4'b1000 mid-scan is served next, with ack[3] and no scan_tick for that pass.
